// File: rtl/sum_tree_acc.sv
// Registered adder tree summing NUM_INPUTS lanes per beat, followed by a frame
// accumulator (saturate or wrap) and a valid/ready output register.
module sum_tree_acc #(
  parameter int NUM_INPUTS = 12,
  parameter int DWIDTH     = 8,
  parameter int SIGNED     = 0,
  parameter int OWIDTH     = 24,
  parameter int SATURATE   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_INPUTS*DWIDTH-1:0] i_dat_vector,
  input  logic                         i_dat_valid,
  input  logic                         i_dat_last,
  output logic                         o_in_ready,
  output logic [OWIDTH-1:0]            o_sum,
  output logic                         o_sum_valid,
  input  logic                         i_sum_ready,
  output logic                         o_ovf
);

  localparam int NUM_STAGES = $clog2(NUM_INPUTS);
  localparam int TW         = DWIDTH + NUM_STAGES;

  // Element count after s halving stages (odd leftovers pass through).
  function automatic int stage_cnt(input int s);
    int c;
    c = NUM_INPUTS;
    for (int k = 0; k < s; k++) c = (c + 1) / 2;
    return c;
  endfunction

  // Bit offset of stage s inside the flat tree register.
  function automatic int stage_off(input int s);
    int o;
    o = 0;
    for (int t = 1; t < s; t++) o = o + stage_cnt(t) * (DWIDTH + t);
    return o;
  endfunction

  localparam int TOTAL = stage_off(NUM_STAGES + 1);

  function automatic logic is_ovf(input logic [OWIDTH:0] v);
    if (SIGNED != 0) return v[OWIDTH] != v[OWIDTH-1];
    return v[OWIDTH];
  endfunction

  function automatic logic [OWIDTH-1:0] clamp(input logic [OWIDTH:0] v);
    if (!is_ovf(v) || SATURATE == 0) return v[OWIDTH-1:0];
    if (SIGNED == 0) return '1;
    return v[OWIDTH] ? {1'b1, {(OWIDTH-1){1'b0}}} : {1'b0, {(OWIDTH-1){1'b1}}};
  endfunction

  logic                  en;
  logic [TOTAL-1:0]      tree_dat_c;
  logic [TOTAL-1:0]      tree_dat_p;
  logic [NUM_STAGES:1]   vld_p;
  logic [NUM_STAGES:1]   last_p;

  assign en         = !o_sum_valid || i_sum_ready;
  assign o_in_ready = en;

  // Tree stages 1..NUM_STAGES: element i pairs with element i+ceil(n/2).
  for (genvar s = 1; s <= NUM_STAGES; s++) begin : g_stg
    localparam int NP    = stage_cnt(s - 1);
    localparam int N     = stage_cnt(s);
    localparam int WP    = DWIDTH + s - 1;
    localparam int W     = DWIDTH + s;
    localparam int OFF_I = (s == 1) ? 0 : stage_off(s - 1);
    localparam int OFF_O = stage_off(s);

    logic [NP*WP-1:0] din;

    if (s == 1) begin : g_in
      assign din = i_dat_vector;
    end else begin : g_mid
      assign din = tree_dat_p[OFF_I +: NP*WP];
    end

    for (genvar i = 0; i < N; i++) begin : g_node
      logic [W-1:0] a;
      assign a = {(SIGNED != 0) & din[i*WP+WP-1], din[i*WP +: WP]};
      if (i + N < NP) begin : g_add
        logic [W-1:0] b;
        assign b = {(SIGNED != 0) & din[(i+N)*WP+WP-1], din[(i+N)*WP +: WP]};
        assign tree_dat_c[OFF_O+i*W +: W] = a + b;
      end else begin : g_pass
        assign tree_dat_c[OFF_O+i*W +: W] = a;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tree_dat_p <= '0;
      vld_p      <= '0;
      last_p     <= '0;
    end else if (en) begin
      tree_dat_p <= tree_dat_c;
      vld_p[1]   <= i_dat_valid;
      last_p[1]  <= i_dat_valid & i_dat_last;
      for (int s = 2; s <= NUM_STAGES; s++) begin
        vld_p[s]  <= vld_p[s-1];
        last_p[s] <= last_p[s-1];
      end
    end
  end

  logic [TW-1:0]     tree_out;
  logic              tree_vld;
  logic              tree_last;
  logic [OWIDTH-1:0] acc;
  logic              first;
  logic              frame_ovf;
  logic [OWIDTH:0]   tree_ext;
  logic [OWIDTH:0]   base;
  logic [OWIDTH:0]   sum_c;
  logic              beat_ovf;
  logic [OWIDTH-1:0] acc_nxt;

  assign tree_out  = tree_dat_p[stage_off(NUM_STAGES) +: TW];
  assign tree_vld  = vld_p[NUM_STAGES];
  assign tree_last = last_p[NUM_STAGES];

  assign tree_ext = {{(OWIDTH+1-TW){(SIGNED != 0) & tree_out[TW-1]}}, tree_out};
  assign base     = first ? '0 : {(SIGNED != 0) & acc[OWIDTH-1], acc};
  assign sum_c    = base + tree_ext;
  assign beat_ovf = is_ovf(sum_c);
  assign acc_nxt  = clamp(sum_c);

  // Accumulator and output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      first       <= 1'b1;
      frame_ovf   <= 1'b0;
      o_sum       <= '0;
      o_ovf       <= 1'b0;
      o_sum_valid <= 1'b0;
    end else if (en) begin
      o_sum_valid <= 1'b0;
      if (tree_vld) begin
        if (tree_last) begin
          o_sum       <= acc_nxt;
          o_ovf       <= frame_ovf | beat_ovf;
          o_sum_valid <= 1'b1;
          acc         <= '0;
          first       <= 1'b1;
          frame_ovf   <= 1'b0;
        end else begin
          acc         <= acc_nxt;
          first       <= 1'b0;
          frame_ovf   <= frame_ovf | beat_ovf;
        end
      end
    end
  end

endmodule
